// File: rtl/led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_frame_scheduler
// Purpose  : Multi-channel PWM frame sequencer. A free-running period counter
//            drives per-channel LED outputs from an active duty bank. Host
//            writes land in a shadow bank. A commit copies shadow to active
//            only at a period boundary, so a frame never changes mid-period.
// Ports    :
//   oscillator      in   clock, rising edge
//   globalReset     in   synchronous active-high reset
//   wr_valid        in   host write request
//   wr_ready        out  write accepted when wr_valid & wr_ready
//   wr_ch           in   target channel index
//   wr_duty         in   duty value for the shadow bank
//   wr_err          out  one-cycle pulse after an accepted out-of-range write
//   commit          in   request shadow->active swap at the next boundary
//   commit_pending  out  swap requested and not yet performed
//   frame_data      out  active duties, channel k at [k*DATA_W +: DATA_W]
//   pwm_cnt         out  period counter, 0 .. 2**DATA_W-2
//   period_start    out  high while pwm_cnt == 0, from the first wrap onward
//   led_on          out  led_on[k] = pwm_cnt < active duty k
// Revision : 1.0 - initial release
// ============================================================================
module led_frame_scheduler #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12,
    parameter int CH_W   = 2
) (
    input  logic                     oscillator,
    input  logic                     globalReset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [DATA_W-1:0]        wr_duty,
    output logic                     wr_err,
    input  logic                     commit,
    output logic                     commit_pending,
    output logic [NUM_CH*DATA_W-1:0] frame_data,
    output logic [DATA_W-1:0]        pwm_cnt,
    output logic                     period_start,
    output logic [NUM_CH-1:0]        led_on
);

    // Last counter value; the all-ones value is skipped so a duty of all-ones
    // keeps the LED on for the whole period.
    localparam logic [DATA_W-1:0] C_MAX_CNT = {{(DATA_W-1){1'b1}}, 1'b0};

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [DATA_W-1:0]          cnt_q, cnt_d;
    logic                       period_start_q;
    logic                       wr_err_q;
    logic [NUM_CH*DATA_W-1:0]   shadow_q, shadow_d;
    logic [NUM_CH*DATA_W-1:0]   active_q, active_d;

    logic                       w_at_max;
    logic                       w_accept;
    logic                       w_hit;
    logic                       w_swap;

    assign w_at_max = (cnt_q == C_MAX_CNT);
    assign cnt_d    = w_at_max ? '0 : cnt_q + 1'b1;
    assign w_accept = wr_valid & wr_ready;

    // Shadow bank update. An index that matches no channel leaves the bank
    // untouched and is reported through wr_err instead.
    always_comb begin
        shadow_d = shadow_q;
        w_hit    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_accept && (wr_ch == CH_W'(k))) begin
                shadow_d[k*DATA_W +: DATA_W] = wr_duty;
                w_hit                        = 1'b1;
            end
        end
    end

    // Commit handshake. commit_pending also reflects a commit being presented
    // in IDLE so the host sees the request acknowledged in the same cycle.
    always_comb begin
        state_d        = state_q;
        wr_ready       = 1'b0;
        commit_pending = 1'b0;
        w_swap         = 1'b0;
        case (state_q)
            S_IDLE: begin
                wr_ready       = 1'b1;
                commit_pending = commit;
                if (commit) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                commit_pending = 1'b1;
                if (w_at_max) begin
                    w_swap  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Writes are blocked while pending, so the swap never races a write.
    assign active_d = w_swap ? shadow_q : active_q;

    always_ff @(posedge oscillator) begin
        if (globalReset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            wr_err_q       <= 1'b0;
            shadow_q       <= '0;
            active_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_start_q <= w_at_max;
            wr_err_q       <= w_accept & ~w_hit;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
        end
    end

    assign pwm_cnt      = cnt_q;
    assign period_start = period_start_q;
    assign wr_err       = wr_err_q;
    assign frame_data   = active_q;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_led
            assign led_on[g] = (cnt_q < active_q[g*DATA_W +: DATA_W]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_frame_scheduler
// Purpose  : Self-checking bench for led_frame_scheduler (4 channels, 4-bit
//            duties, period of 15 cycles). Committed frames are queued when
//            the commit is issued and compared when the swap appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_frame_scheduler;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 4;
    localparam int CH_W   = 3;
    localparam int PERIOD = 15;

    logic                     clk;
    logic                     rst;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [CH_W-1:0]          wr_ch;
    logic [DATA_W-1:0]        wr_duty;
    logic                     wr_err;
    logic                     commit;
    logic                     commit_pending;
    logic [NUM_CH*DATA_W-1:0] frame_data;
    logic [DATA_W-1:0]        pwm_cnt;
    logic                     period_start;
    logic [NUM_CH-1:0]        led_on;

    led_frame_scheduler #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) dut (
        .oscillator     (clk),
        .globalReset    (rst),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_ch          (wr_ch),
        .wr_duty        (wr_duty),
        .wr_err         (wr_err),
        .commit         (commit),
        .commit_pending (commit_pending),
        .frame_data     (frame_data),
        .pwm_cnt        (pwm_cnt),
        .period_start   (period_start),
        .led_on         (led_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected counter value and bank contents, kept independently of the DUT.
    int                 n;
    logic [DATA_W-1:0]  sh  [NUM_CH];
    logic [DATA_W-1:0]  act [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] exp_q [$];

    function automatic logic [NUM_CH*DATA_W-1:0] pack_sh();
        return {sh[3], sh[2], sh[1], sh[0]};
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] pack_act();
        return {act[3], act[2], act[1], act[0]};
    endfunction

    function automatic logic [NUM_CH-1:0] led_exp();
        logic [NUM_CH-1:0] e;
        for (int k = 0; k < NUM_CH; k++) e[k] = (n < int'(act[k]));
        return e;
    endfunction

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        if (r) n = 0;
        else   n = (n + 1) % PERIOD;
    endtask

    task automatic wait_cnt(input int v);
        for (int i = 0; i < PERIOD + 1 && n != v; i++) tick();
    endtask

    task automatic do_write(input int ch, input int duty);
        wr_valid = 1'b1;
        wr_ch    = CH_W'(ch);
        wr_duty  = DATA_W'(duty);
        tick();
        wr_valid = 1'b0;
        if (ch < NUM_CH) sh[ch] = DATA_W'(duty);
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        exp_q.push_back(pack_sh());
    endtask

    // Move to the next wrap and compare the swapped frame with the queued one.
    task automatic wait_swap(input string name);
        logic [NUM_CH*DATA_W-1:0] e;
        for (int i = 0; i < PERIOD + 1 && n != 0; i++) tick();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (frame_data !== e || commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL %s_swap: frame=%h pend=%b want frame=%h pend=0",
                     name, frame_data, commit_pending, e);
        end
        for (int k = 0; k < NUM_CH; k++) act[k] = e[k*DATA_W +: DATA_W];
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_ch = '0; wr_duty = '0; commit = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({pwm_cnt, wr_ready, wr_err, commit_pending, period_start, frame_data, led_on}
            !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset: cnt=%0d rdy=%b err=%b pend=%b ps=%b frame=%h led=%b",
                     pwm_cnt, wr_ready, wr_err, commit_pending, period_start, frame_data, led_on);
        end
        rst = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin sh[k] = '0; act[k] = '0; end
        exp_q.delete();
    endtask

    task automatic test_period();
        for (int i = 1; i <= 3 * PERIOD; i++) begin
            tick();
            checks++;
            if (pwm_cnt !== DATA_W'(n) || period_start !== (n == 0) || led_on !== 4'h0) begin
                errors++;
                $display("FAIL period cyc%0d: cnt=%0d ps=%b led=%b want cnt=%0d ps=%b led=0",
                         i, pwm_cnt, period_start, led_on, n, (n == 0));
            end
        end
    endtask

    task automatic test_write_commit();
        wait_cnt(2);
        do_write(0, 5);
        do_write(1, 15);
        do_commit();
        wait_cnt(14);
        checks++;
        if (frame_data !== 16'h0 || commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL early_swap: frame=%h pend=%b want frame=0000 pend=1",
                     frame_data, commit_pending);
        end
        wait_swap("basic");
        checks++;
        if (frame_data[3:0] !== 4'd5) begin
            errors++;
            $display("FAIL ch0_duty: got %0d want 5", frame_data[3:0]);
        end
        for (int i = 0; i < PERIOD; i++) begin
            checks++;
            if (led_on !== led_exp()) begin
                errors++;
                $display("FAIL led_basic cnt%0d: got %b want %b", n, led_on, led_exp());
            end
            tick();
        end
    endtask

    task automatic test_midperiod();
        wait_cnt(3);
        do_write(2, 7);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (frame_data !== pack_act() || led_on !== led_exp()) begin
                errors++;
                $display("FAIL mid_glitch cnt%0d: frame=%h led=%b want frame=%h led=%b",
                         n, frame_data, led_on, pack_act(), led_exp());
            end
            tick();
        end
        wait_cnt(6);
        do_commit();
        wait_swap("mid");
        for (int i = 0; i < PERIOD; i++) begin
            checks++;
            if (led_on !== led_exp()) begin
                errors++;
                $display("FAIL led_mid cnt%0d: got %b want %b", n, led_on, led_exp());
            end
            tick();
        end
    endtask

    task automatic test_commit_at_max();
        int cnt_p;
        do_write(3, 9);
        wait_cnt(14);
        commit = 1'b1;
        #1;
        cnt_p = commit_pending ? 1 : 0;
        tick();
        commit = 1'b0;
        while (commit_pending === 1'b1 && cnt_p < 40) begin
            cnt_p++;
            checks++;
            if (frame_data !== pack_act()) begin
                errors++;
                $display("FAIL max_early cnt%0d: frame=%h want %h", n, frame_data, pack_act());
            end
            tick();
        end
        checks++;
        if (cnt_p !== 16 || pwm_cnt !== 4'd0 || frame_data !== pack_sh()) begin
            errors++;
            $display("FAIL commit_at_max: pend_cycles=%0d cnt=%0d frame=%h want 16,0,%h",
                     cnt_p, pwm_cnt, frame_data, pack_sh());
        end
        for (int k = 0; k < NUM_CH; k++) act[k] = sh[k];
    endtask

    task automatic test_back_to_back();
        wait_cnt(5);
        do_commit();
        wr_valid = 1'b1; wr_ch = 3'd0; wr_duty = 4'd3;
        for (int i = 0; i < PERIOD + 1 && n != 0; i++) begin
            checks++;
            if (wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL pend_ready cnt%0d: got %b want 0", n, wr_ready);
            end
            tick();
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b want 1", wr_ready);
        end
        wait_swap("held");
        tick();
        wr_valid = 1'b0;
        sh[0] = 4'd3;
        checks++;
        if (frame_data[3:0] !== act[0]) begin
            errors++;
            $display("FAIL held_write_active: got %0d want %0d", frame_data[3:0], act[0]);
        end
        // Write and commit in the same cycle: the write is part of the swap.
        wait_cnt(4);
        wr_valid = 1'b1; wr_ch = 3'd1; wr_duty = 4'd2; commit = 1'b1;
        tick();
        wr_valid = 1'b0; commit = 1'b0;
        sh[1] = 4'd2;
        exp_q.push_back(pack_sh());
        wait_swap("same_cycle");
    endtask

    task automatic test_bad_ch();
        wait_cnt(1);
        wr_valid = 1'b1; wr_ch = 3'd5; wr_duty = 4'd11;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || wr_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_ch_accept: rdy=%b err=%b want 1 0", wr_ready, wr_err);
        end
        tick();
        wr_valid = 1'b0;
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_pulse: got %b want 1", wr_err);
        end
        tick();
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_clear: got %b want 0", wr_err);
        end
        do_write(0, 8);
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_valid_ch: got %b want 0", wr_err);
        end
        wait_cnt(2);
        do_commit();
        wait_swap("bad_ch");
    endtask

    task automatic test_last_wins();
        logic [NUM_CH*DATA_W-1:0] prev;
        wait_cnt(1);
        do_write(3, 1);
        do_write(3, 12);
        do_commit();
        wait_swap("last_wins");
        prev = frame_data;
        wait_cnt(4);
        do_commit();
        wait_swap("reapply");
        checks++;
        if (frame_data !== prev) begin
            errors++;
            $display("FAIL reapply_same: got %h want %h", frame_data, prev);
        end
    endtask

    task automatic test_reset_pending();
        wait_cnt(3);
        do_commit();
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if (commit_pending !== 1'b0 || frame_data !== 16'h0 || pwm_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_pending: pend=%b frame=%h cnt=%0d want 0 0000 0",
                     commit_pending, frame_data, pwm_cnt);
        end
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < NUM_CH; k++) begin sh[k] = '0; act[k] = '0; end
        wait_cnt(2);
        do_commit();
        wait_swap("post_reset");
        checks++;
        if (led_on !== 4'h0) begin
            errors++;
            $display("FAIL post_reset_led: got %b want 0000", led_on);
        end
    endtask

    initial begin
        n = 0;
        test_reset();
        test_period();
        test_write_commit();
        test_midperiod();
        test_commit_at_max();
        test_back_to_back();
        test_bad_ch();
        test_last_wins();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
